instr_mem_loader: RTL and testbench

Writable instruction memory with a streaming program loader, the write-side counterpart to the fetch path. The loader accepts 9-bit machine-code words over a valid/ready stream, writes them into consecutive addresses starting at 0, and holds the core off while loading. The fetch port reads combinationally, in the same way the core's existing instruction lookup does. It sits between the testbench/host program source and the core's program-counter fetch.

---
 rtl/instr_mem_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writable instruction memory with a streaming program loader.
//
// A host streams 9-bit machine-code words over a valid/ready handshake. The
// words are written to consecutive addresses starting at 0, and busy holds the
// core off while the load runs. The fetch port reads combinationally.
//
// Ports
//   Clk        clock, all state updates on the rising edge
//   Reset_n    synchronous active-low reset
//   start      one-cycle load request, honoured only in IDLE or DONE
//   len        number of words to load (0..2**D), sampled with start
//   in_valid   host presents a word on in_data
//   in_data    machine-code word
//   in_ready   loader accepts a word this cycle
//   prog_ctr   fetch address
//   mach_code  memory word at prog_ctr (combinational)
//   busy       load in progress
//   done       last load completed, held until the next accepted start
//   error      last start asked for more than 2**D words
//   word_cnt   words written in the current or last load
//   checksum   running XOR of the words written in the current or last load
module instr_mem_loader #(
  parameter int D = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic         in_valid,
  input  logic [8:0]   in_data,
  output logic         in_ready,
  input  logic [D-1:0] prog_ctr,
  output logic [8:0]   mach_code,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [D:0]   word_cnt,
  output logic [8:0]   checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DEPTH    = 2 ** D;
  localparam logic [D:0]  LEN_MAX  = {1'b1, {D{1'b0}}};
  localparam logic [D:0]  ONE_CNT  = {{D{1'b0}}, 1'b1};
  localparam logic [D-1:0] ONE_ADDR = {{(D-1){1'b0}}, 1'b1};

  // Checksum accumulation step: fold one more word into the running XOR.
  function automatic logic [8:0] checksum_step(input logic [8:0] acc, input logic [8:0] word);
    return acc ^ word;
  endfunction

  logic [8:0]   core [DEPTH];

  state_t       state_r, state_s;
  logic [D-1:0] wr_addr_r, wr_addr_s;
  logic [D:0]   cnt_r, cnt_s;
  logic [D:0]   len_r, len_s;
  logic [8:0]   cs_r, cs_s;
  logic         done_r, done_s;
  logic         error_r, error_s;
  logic         busy_r;
  logic         ready_r;
  logic         wr_en_s;

  // A transfer happens whenever the loader is in LOAD and the host is valid.
  assign wr_en_s = (state_r == ST_LOAD) && in_valid;

  // Next-state and next-value logic for the loader FSM.
  always_comb begin
    state_s   = state_r;
    wr_addr_s = wr_addr_r;
    cnt_s     = cnt_r;
    len_s     = len_r;
    cs_s      = cs_r;
    done_s    = done_r;
    error_s   = error_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len > LEN_MAX) begin
            state_s = ST_IDLE;
            error_s = 1'b1;
            done_s  = 1'b0;
          end else if (len == {(D+1){1'b0}}) begin
            state_s = ST_DONE;
            cnt_s   = {(D+1){1'b0}};
            cs_s    = 9'd0;
            error_s = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s   = ST_LOAD;
            wr_addr_s = {D{1'b0}};
            cnt_s     = {(D+1){1'b0}};
            cs_s      = 9'd0;
            len_s     = len;
            error_s   = 1'b0;
            done_s    = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          // wr_addr may wrap after the final word of a full-depth load, but
          // the FSM leaves LOAD on that same edge so no write follows.
          wr_addr_s = wr_addr_r + ONE_ADDR;
          cnt_s     = cnt_r + ONE_CNT;
          cs_s      = checksum_step(cs_r, in_data);
          if ((cnt_r + ONE_CNT) == len_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      wr_addr_r <= {D{1'b0}};
      cnt_r     <= {(D+1){1'b0}};
      len_r     <= {(D+1){1'b0}};
      cs_r      <= 9'd0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      wr_addr_r <= wr_addr_s;
      cnt_r     <= cnt_s;
      len_r     <= len_s;
      cs_r      <= cs_s;
      done_r    <= done_s;
      error_r   <= error_s;
      busy_r    <= (state_s == ST_LOAD);
      ready_r   <= (state_s == ST_LOAD);
    end
  end

  // Memory write port; no reset so contents survive reset and later loads.
  // A reset edge suppresses the write so an aborted load stops immediately.
  always_ff @(posedge Clk) begin
    if (Reset_n && wr_en_s) begin
      core[wr_addr_r] <= in_data;
    end
  end

  assign mach_code = core[prog_ctr];
  assign in_ready  = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign word_cnt  = cnt_r;
  assign checksum  = cs_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader. Load tasks push the expected word count and
// checksum of each completed load into a queue; a monitor pops and compares
// whenever done rises. Directed checks cover handshake timing and memory.
module tb_instr_mem_loader;

  localparam int D = 9;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         start;
  logic [D:0]   len;
  logic         in_valid;
  logic [8:0]   in_data;
  logic         in_ready;
  logic [D-1:0] prog_ctr;
  logic [8:0]   mach_code;
  logic         busy;
  logic         done;
  logic         error;
  logic [D:0]   word_cnt;
  logic [8:0]   checksum;

  instr_mem_loader #(.D(D)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prog_ctr  (prog_ctr),
    .mach_code (mach_code),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_cnt  (word_cnt),
    .checksum  (checksum)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [D:0] cnt;
    logic [8:0] cs;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] words[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       done_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic chk_mem(input string name, input int addr, input logic [8:0] req);
    prog_ctr = D'(addr);
    #1;
    chk(name, {23'd0, mach_code}, {23'd0, req});
  endtask

  // Scoreboard monitor: every rising done must match the oldest expected load.
  always @(negedge Clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word_cnt", {22'd0, word_cnt}, {22'd0, e.cnt});
        chk("sb_checksum", {23'd0, checksum}, {23'd0, e.cs});
      end
    end
    done_q <= done;
  end

  // Streams the words queue as one load; optional stall with a start pulse,
  // optional read-during-write check at prog_ctr = 0.
  task automatic run_load(input int stall_after, input int stall_cycles, input bit rdw, input logic [8:0] old0);
    int         n;
    logic [8:0] cs;
    n  = words.size();
    cs = 9'd0;
    foreach (words[k]) cs = cs ^ words[k];
    exp_q.push_back('{cnt: (D+1)'(n), cs: cs});
    @(posedge Clk); #1;
    start = 1'b1;
    len   = (D+1)'(n);
    @(posedge Clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, in_ready}, 32'd1);
    if (rdw) begin
      prog_ctr = '0;
      #1;
      chk("rdw_old", {23'd0, mach_code}, {23'd0, old0});
    end
    for (int i = 0; i < n; i++) begin
      if (i == stall_after) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          if (s == 0) begin
            start = 1'b1;
            len   = (D+1)'(1);
          end
          @(posedge Clk); #1;
          start = 1'b0;
          chk("stall_cnt", {22'd0, word_cnt}, i);
          chk("stall_ready", {31'd0, in_ready}, 32'd1);
          chk("stall_busy", {31'd0, busy}, 32'd1);
        end
      end
      in_valid = 1'b1;
      in_data  = words[i];
      @(posedge Clk); #1;
      if (rdw && i == 0) chk("rdw_new", {23'd0, mach_code}, {23'd0, words[0]});
      if (n <= 8 || i == n - 1) begin
        chk("xfer_done", {31'd0, done}, (i == n - 1) ? 32'd1 : 32'd0);
        chk("xfer_cnt", {22'd0, word_cnt}, i + 1);
      end
    end
    in_valid = 1'b0;
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = 9'd0;
    prog_ctr = '0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_cnt", {22'd0, word_cnt}, 32'd0);
    chk("rst_cs", {23'd0, checksum}, 32'd0);

    // Preload known contents at addresses 0..4.
    words = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
    run_load(-1, 0, 1'b0, 9'd0);

    // Basic load with read-during-write at address 0.
    words = '{9'b001111110, 9'b001100110, 9'b001111010};
    run_load(-1, 0, 1'b1, 9'h101);
    chk("basic_cs", {23'd0, checksum}, {23'd0, 9'b001100010});
    chk("basic_cnt", {22'd0, word_cnt}, 32'd3);
    chk_mem("basic_m0", 0, 9'b001111110);
    chk_mem("basic_m1", 1, 9'b001100110);
    chk_mem("basic_m2", 2, 9'b001111010);
    chk_mem("retain_m3", 3, 9'h104);
    chk_mem("retain_m4", 4, 9'h105);

    // in_valid in DONE must not write or count.
    in_valid = 1'b1;
    in_data  = 9'h1FF;
    repeat (2) @(posedge Clk);
    #1;
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    chk("done_cnt", {22'd0, word_cnt}, 32'd3);
    in_valid = 1'b0;
    chk_mem("done_m0", 0, 9'b001111110);
    chk_mem("done_m3", 3, 9'h104);

    // Stalled stream with an ignored start pulse during the stall.
    words = '{9'h011, 9'h022, 9'h044, 9'h088};
    run_load(2, 3, 1'b0, 9'd0);
    chk_mem("stall_m2", 2, 9'h044);
    chk_mem("stall_m3", 3, 9'h088);

    // Reset mid-load, asserted together with start.
    @(posedge Clk); #1;
    start = 1'b1;
    len   = (D+1)'(5);
    @(posedge Clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'h0A1;
    @(posedge Clk); #1;
    in_data = 9'h0A2;
    @(posedge Clk); #1;
    chk("mid_cnt", {22'd0, word_cnt}, 32'd2);
    Reset_n = 1'b0;
    start   = 1'b1;
    in_data = 9'h0A3;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    start   = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_cnt", {22'd0, word_cnt}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd0);
    in_data = 9'h1FF;
    repeat (2) @(posedge Clk);
    #1 in_valid = 1'b0;
    chk_mem("abort_m0", 0, 9'h0A1);
    chk_mem("abort_m1", 1, 9'h0A2);
    chk_mem("abort_m2", 2, 9'h044);
    chk_mem("abort_m3", 3, 9'h088);
    chk_mem("abort_m4", 4, 9'h105);

    // len = 2**D + 1 flags an error and stays idle.
    @(posedge Clk); #1;
    start    = 1'b1;
    len      = (D+1)'(513);
    in_valid = 1'b1;
    in_data  = 9'h1EE;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("err_error", {31'd0, error}, 32'd1);
    chk("err_done", {31'd0, done}, 32'd0);
    chk("err_ready", {31'd0, in_ready}, 32'd0);
    chk("err_busy", {31'd0, busy}, 32'd0);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk_mem("err_m0", 0, 9'h0A1);

    // len = 0 completes next cycle with no writes.
    exp_q.push_back('{cnt: '0, cs: 9'd0});
    start = 1'b1;
    len   = '0;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_error", {31'd0, error}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk_mem("zero_m0", 0, 9'h0A1);

    // Full-depth load: 2**D words.
    words.delete();
    for (int i = 0; i < 512; i++) words.push_back(9'((i * 37 + 11) % 512));
    run_load(-1, 0, 1'b0, 9'd0);
    chk("full_cnt", {22'd0, word_cnt}, 32'd512);
    chk_mem("full_m0", 0, 9'h00B);
    chk_mem("full_m511", 511, 9'h1E6);

    repeat (2) @(posedge Clk);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
